// File: rtl/rwc_pkg.sv
// rwc_pkg: shared state encoding and default widths for the collision engine
package rwc_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SETTLE  = 3'd2,
    COLLIDE = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;
endpackage

// File: rtl/rwc_edge_capture.sv
// rwc_edge_capture: rising- and falling-edge samplers of BRAM port-B data
//  w_clk, w_resetn : clock, synchronous active-low reset
//  cap_set         : next cycle is the last capture cycle (doutb valid)
//  din             : BRAM port-B read data
//  rsp_pos/rsp_neg : data sampled at the closing rising edge / the falling edge before it
module rwc_edge_capture #(
  parameter int DATA_W = 32
) (
  input  logic              w_clk,
  input  logic              w_resetn,
  input  logic              cap_set,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rsp_pos,
  output logic [DATA_W-1:0] rsp_neg
);
  logic              cap_en;
  logic [DATA_W-1:0] neg_q;
  always_ff @(posedge w_clk)
    if (!w_resetn) begin
      cap_en  <= 1'b0;
      rsp_pos <= '0;
      rsp_neg <= '0;
    end else begin
      cap_en <= cap_set;
      if (cap_en) begin
        rsp_pos <= din;
        rsp_neg <= neg_q;
      end
    end
  // The only falling-edge flop; gated by the posedge flag so it samples mid-cycle exactly once.
  always_ff @(negedge w_clk)
    if (cap_en) neg_q <= din;
endmodule

// File: rtl/rwc_collision_engine.sv
// rwc_collision_engine: challenge responder forcing a TDP BRAM read-write collision
//  w_clk, w_resetn      : clock, synchronous active-low reset
//  gen_enable           : start request (level), re-armed only after a low sample in IDLE
//  cha_data, cha_addr   : challenge, captured on accept
//  available, busy      : response-valid pulse, run in progress
//  rsp_pos, rsp_neg     : port-B data captured at rising / falling edge
//  bram_*               : port A write and port B read controls to the BRAM
module rwc_collision_engine
  import rwc_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int SETTLE_CYCLES = 2,
  parameter int READ_LATENCY  = 2
) (
  input  logic              w_clk,
  input  logic              w_resetn,
  input  logic              gen_enable,
  input  logic [DATA_W-1:0] cha_data,
  input  logic [ADDR_W-1:0] cha_addr,
  output logic              available,
  output logic              busy,
  output logic [DATA_W-1:0] rsp_pos,
  output logic [DATA_W-1:0] rsp_neg,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);
  localparam int CW = 8;
  state_t            state, nxt;
  logic              armed, start, last, cap_set;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  assign start = state == IDLE && gen_enable && armed;
  assign last  = cnt == CW'(1);
  // Flag the final CAPTURE cycle one cycle ahead so the capture flop is registered.
  assign cap_set = nxt == CAPTURE && (state == CAPTURE ? cnt == CW'(2) : READ_LATENCY == 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? INIT : IDLE;
      INIT:    nxt = SETTLE;
      SETTLE:  nxt = last ? COLLIDE : SETTLE;
      COLLIDE: nxt = CAPTURE;
      CAPTURE: nxt = last ? DONE : CAPTURE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the port values match the state they belong to.
  always_ff @(posedge w_clk)
    if (!w_resetn) begin
      state      <= IDLE;
      armed      <= 1'b1;
      cnt        <= '0;
      data       <= '0;
      addr       <= '0;
      available  <= 1'b0;
      busy       <= 1'b0;
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      bram_enb   <= 1'b0;
      bram_addra <= '0;
      bram_addrb <= '0;
      bram_dina  <= '0;
    end else begin
      state <= nxt;
      cnt   <= nxt == SETTLE && state != SETTLE ? CW'(SETTLE_CYCLES) :
               nxt == CAPTURE && state != CAPTURE ? CW'(READ_LATENCY) : cnt - 1'b1;
      if (start) begin
        data <= cha_data;
        addr <= cha_addr;
      end
      armed      <= state == DONE ? 1'b0 : (state == IDLE && !gen_enable) ? 1'b1 : armed;
      available  <= nxt == DONE;
      busy       <= nxt != IDLE;
      bram_ena   <= nxt == INIT || nxt == COLLIDE;
      bram_wea   <= nxt == INIT || nxt == COLLIDE;
      bram_enb   <= nxt == COLLIDE || (nxt == CAPTURE && READ_LATENCY == 2);
      bram_addra <= start ? cha_addr : addr;
      bram_addrb <= start ? cha_addr : addr;
      bram_dina  <= start ? ~cha_data : data;
    end
  rwc_edge_capture #(.DATA_W(DATA_W)) u_cap (
    .w_clk    (w_clk),
    .w_resetn (w_resetn),
    .cap_set  (cap_set),
    .din      (bram_doutb),
    .rsp_pos  (rsp_pos),
    .rsp_neg  (rsp_neg)
  );
endmodule
